// File: rtl/sig_mul_seq_pkg.sv
// Shared constants and state encoding for the iterative significand multiplier.
package sig_mul_seq_pkg;

    localparam int NEXP_DEF = 8;
    localparam int NSIG_DEF = 7;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MUL  = 2'd1,
        NORM = 2'd2,
        DONE = 2'd3
    } state_t;

    // Exponent bias for an NEXP-bit biased exponent field.
    function automatic int bias_of(input int nexp);
        return (1 << (nexp - 1)) - 1;
    endfunction

    // Width of the raw / normalized product significand.
    function automatic int pw_of(input int nsig);
        return 2 * nsig + 2;
    endfunction

    localparam int BIAS_DEF = (1 << (NEXP_DEF - 1)) - 1;
    localparam int PW_DEF   = 2 * NSIG_DEF + 2;

endpackage

// File: rtl/sig_normalize.sv
// One-step product normalizer: puts the leading 1 at the MSB when the raw
// product has it at MSB or MSB-1, and flags an all-zero product.
module sig_normalize
    import sig_mul_seq_pkg::*;
#(
    parameter int NEXP = NEXP_DEF,
    parameter int NSIG = NSIG_DEF
) (
    input  logic [pw_of(NSIG)-1:0] p,
    input  logic [NEXP+1:0]        exp_in,
    output logic [pw_of(NSIG)-1:0] sig,
    output logic [NEXP+1:0]        exp_out,
    output logic                   zero
);

    localparam int PW = pw_of(NSIG);

    // Select between pass-through, single left shift, or zero result.
    always_comb begin
        sig     = '0;
        exp_out = '0;
        zero    = 1'b0;
        if (p[PW-1]) begin
            sig     = p;
            exp_out = exp_in + (NEXP+2)'(1);
        end else if (p != '0) begin
            sig     = p << 1;
            exp_out = exp_in;
        end else begin
            zero    = 1'b1;
        end
    end

endmodule

// File: rtl/sig_mul_seq.sv
// Iterative shift-add significand multiplier feeding the FPU rounding stage.
// One multiplier bit is consumed per MUL cycle, so latency is fixed.
module sig_mul_seq
    import sig_mul_seq_pkg::*;
#(
    parameter int NEXP = NEXP_DEF,
    parameter int NSIG = NSIG_DEF
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic                   in_signA,
    input  logic [NEXP-1:0]        in_expA,
    input  logic [NSIG:0]          in_sigA,
    input  logic                   in_signB,
    input  logic [NEXP-1:0]        in_expB,
    input  logic [NSIG:0]          in_sigB,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic                   out_sign,
    output logic [NEXP+1:0]        out_exp,
    output logic [2*NSIG+1:0]      out_pSig,
    output logic                   out_zero
);

    localparam int PW = pw_of(NSIG);
    localparam int CW = $clog2(NSIG + 2);
    localparam logic [CW-1:0]   LAST   = CW'(NSIG);
    localparam logic [NEXP+1:0] BIAS_V = (NEXP+2)'(bias_of(NEXP));

    state_t          state;
    logic [PW-1:0]   acc;
    logic [PW-1:0]   a_sh;     // multiplicand, pre-shifted by the iteration index
    logic [NSIG:0]   b_sh;     // multiplier, bit 0 is the current iteration's bit
    logic [CW-1:0]   cnt;
    logic            sign_r;
    logic [NEXP+1:0] exp_sum;

    logic [PW-1:0]   n_sig;
    logic [NEXP+1:0] n_exp;
    logic            n_zero;

    assign in_ready = (state == IDLE);

    sig_normalize #(.NEXP(NEXP), .NSIG(NSIG)) u_norm (
        .p       (acc),
        .exp_in  (exp_sum),
        .sig     (n_sig),
        .exp_out (n_exp),
        .zero    (n_zero)
    );

    // Control FSM plus datapath: accept, NSIG+1 shift-add steps, normalize, hold.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            acc       <= '0;
            a_sh      <= '0;
            b_sh      <= '0;
            cnt       <= '0;
            sign_r    <= 1'b0;
            exp_sum   <= '0;
            out_valid <= 1'b0;
            out_sign  <= 1'b0;
            out_exp   <= '0;
            out_pSig  <= '0;
            out_zero  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        a_sh    <= PW'(in_sigA);
                        b_sh    <= in_sigB;
                        acc     <= '0;
                        cnt     <= '0;
                        sign_r  <= in_signA ^ in_signB;
                        exp_sum <= {2'b00, in_expA} + {2'b00, in_expB} - BIAS_V;
                        state   <= MUL;
                    end
                end
                MUL: begin
                    if (b_sh[0])
                        acc <= acc + a_sh;
                    a_sh <= a_sh << 1;
                    b_sh <= b_sh >> 1;
                    cnt  <= cnt + CW'(1);
                    if (cnt == LAST)
                        state <= NORM;
                end
                NORM: begin
                    out_pSig  <= n_sig;
                    out_exp   <= n_exp;
                    out_zero  <= n_zero;
                    out_sign  <= sign_r;
                    out_valid <= 1'b1;
                    state     <= DONE;
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_sig_mul_seq.sv
// Randomized self-checking bench for sig_mul_seq against an arithmetic model.
module tb_sig_mul_seq;

    localparam int NEXP = 8;
    localparam int NSIG = 7;
    localparam int PW   = 2 * NSIG + 2;
    localparam int BIAS = (1 << (NEXP - 1)) - 1;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic            in_valid = 1'b0;
    logic            in_ready;
    logic            in_signA = 1'b0, in_signB = 1'b0;
    logic [NEXP-1:0] in_expA = '0, in_expB = '0;
    logic [NSIG:0]   in_sigA = '0, in_sigB = '0;
    logic            out_valid;
    logic            out_ready = 1'b0;
    logic            out_sign;
    logic [NEXP+1:0] out_exp;
    logic [PW-1:0]   out_pSig;
    logic            out_zero;

    int checks = 0;
    int failures = 0;

    sig_mul_seq #(.NEXP(NEXP), .NSIG(NSIG)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_signA(in_signA), .in_expA(in_expA), .in_sigA(in_sigA),
        .in_signB(in_signB), .in_expB(in_expB), .in_sigB(in_sigB),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_sign(out_sign), .out_exp(out_exp),
        .out_pSig(out_pSig), .out_zero(out_zero)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // Reference: plain integer product and exponent, then one-step normalize.
    function automatic void model(input bit sa, input bit sb, input int ea, input int eb,
                                  input int siga, input int sigb,
                                  output logic [PW-1:0] psig, output logic [NEXP+1:0] e,
                                  output bit s, output bit z);
        int p, sum;
        p   = siga * sigb;
        sum = ea + eb - BIAS;
        s   = sa ^ sb;
        z   = 1'b0;
        if (p == 0) begin
            psig = '0; e = '0; z = 1'b1;
        end else if (p >= (1 << (PW - 1))) begin
            psig = PW'(p); e = (NEXP+2)'(sum + 1);
        end else begin
            psig = PW'(p * 2); e = (NEXP+2)'(sum);
        end
    endfunction

    task automatic drive_ops(input bit sa, input int ea, input int siga,
                             input bit sb, input int eb, input int sigb);
        in_signA = sa; in_expA = NEXP'(ea); in_sigA = (NSIG+1)'(siga);
        in_signB = sb; in_expB = NEXP'(eb); in_sigB = (NSIG+1)'(sigb);
    endtask

    task automatic scramble_ops();
        drive_ops(1'($urandom), $urandom, $urandom, 1'($urandom), $urandom, $urandom);
    endtask

    task automatic check_out(input string tag, input bit sa, input int ea, input int siga,
                             input bit sb, input int eb, input int sigb);
        logic [PW-1:0] ep; logic [NEXP+1:0] ee; bit es, ez;
        model(sa, sb, ea, eb, siga, sigb, ep, ee, es, ez);
        chk({tag, ".psig"}, 32'(out_pSig), 32'(ep));
        chk({tag, ".exp"},  32'(out_exp),  32'(ee));
        chk({tag, ".sign"}, 32'(out_sign), 32'(es));
        chk({tag, ".zero"}, 32'(out_zero), 32'(ez));
    endtask

    // Count edges from the accept edge (inclusive) until out_valid is seen.
    task automatic wait_valid(input string tag);
        int lat = 1;
        while (!out_valid && lat < 40) begin
            @(posedge clk); #1; lat++;
        end
        chk({tag, ".lat"}, 32'(lat), 32'(NSIG + 3));
    endtask

    // One full transaction with `hold` cycles of backpressure after out_valid.
    task automatic run_op(input string tag, input bit sa, input int ea, input int siga,
                          input bit sb, input int eb, input int sigb, input int hold);
        int w = 0;
        while (!in_ready && w < 40) begin
            @(posedge clk); #1; w++;
        end
        chk({tag, ".rdy"}, 32'(in_ready), 32'd1);
        drive_ops(sa, ea, siga, sb, eb, sigb);
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        scramble_ops();
        wait_valid(tag);
        check_out(tag, sa, ea, siga, sb, eb, sigb);
        for (int k = 0; k < hold; k++) begin
            in_valid = 1'($urandom);
            scramble_ops();
            @(posedge clk); #1;
            chk({tag, ".bp_vld"}, 32'(out_valid), 32'd1);
            chk({tag, ".bp_rdy"}, 32'(in_ready), 32'd0);
            check_out({tag, ".bp"}, sa, ea, siga, sb, eb, sigb);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        chk({tag, ".pop_vld"}, 32'(out_valid), 32'd0);
        chk({tag, ".pop_rdy"}, 32'(in_ready), 32'd1);
    endtask

    initial begin
        int acc_e[2];
        int n;

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        chk("rst.vld",  32'(out_valid), 32'd0);
        chk("rst.psig", 32'(out_pSig),  32'd0);
        chk("rst.exp",  32'(out_exp),   32'd0);
        chk("rst.sign", 32'(out_sign),  32'd0);
        chk("rst.zero", 32'(out_zero),  32'd0);
        rst = 1'b0;
        @(posedge clk); #1;
        chk("rst.rdy",  32'(in_ready),  32'd1);

        // Directed cases
        run_op("d15x15", 0, 127, 'hC0, 0, 127, 'hC0, 0);
        chk("d15x15.abs", 32'(out_pSig), 32'h9000);
        run_op("d1xm1",  0, 127, 'h80, 1, 127, 'h80, 0);
        chk("d1xm1.abs", 32'(out_pSig), 32'h8000);
        run_op("dffff",  0, 130, 'hFF, 0, 120, 'hFF, 1);
        chk("dffff.abs", 32'(out_pSig), 32'hFE01);
        run_op("dzero",  1, 77,  'h00, 0, 200, 'hA0, 0);
        run_op("dlowe",  0, 1,   'h80, 0, 1,   'h80, 0);
        chk("dlowe.abs", 32'(out_exp), 32'h383);
        run_op("dbp",    1, 140, 'hB3, 1, 99,  'hE7, 6);

        // Reset in the 4th MUL cycle discards the operation
        drive_ops(0, 127, 'hC0, 0, 127, 'hC0);
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (3) begin @(posedge clk); #1; end
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        chk("mrst.rdy", 32'(in_ready),  32'd1);
        chk("mrst.vld", 32'(out_valid), 32'd0);
        run_op("mrst15", 0, 127, 'hC0, 0, 127, 'hC0, 0);

        // Throughput with out_ready held high: accepts NSIG+4 edges apart
        acc_e[0] = 0; acc_e[1] = 0; n = 0;
        out_ready = 1'b1;
        drive_ops(0, 100, 'h9D, 1, 150, 'hC4);
        in_valid = 1'b1;
        for (int e = 0; e < 60 && n < 2; e++) begin
            if (in_ready) begin
                acc_e[n] = e;
                n++;
            end
            @(posedge clk); #1;
            if (n == 1) drive_ops(1, 33, 'hF1, 1, 210, 'h8B);
        end
        in_valid = 1'b0;
        chk("thru.n",  32'(n), 32'd2);
        chk("thru.per", 32'(acc_e[1] - acc_e[0]), 32'(NSIG + 4));
        wait_valid("thru2");
        check_out("thru2", 1, 33, 'hF1, 1, 210, 'h8B);
        @(posedge clk); #1;
        out_ready = 1'b0;

        // Randomized operands, including denormal and zero significands
        for (int t = 0; t < 25; t++) begin
            int sa_, sb_, ea_, eb_, ga, gb, r;
            sa_ = $urandom_range(0, 1);
            sb_ = $urandom_range(0, 1);
            ea_ = $urandom_range(0, (1 << NEXP) - 1);
            eb_ = $urandom_range(0, (1 << NEXP) - 1);
            r   = $urandom_range(0, 9);
            ga  = (r == 0) ? 0 : (r == 1) ? $urandom_range(0, 127) : $urandom_range(128, 255);
            r   = $urandom_range(0, 9);
            gb  = (r == 0) ? 0 : (r == 1) ? $urandom_range(0, 127) : $urandom_range(128, 255);
            run_op("rnd", 1'(sa_), ea_, ga, 1'(sb_), eb_, gb, $urandom_range(0, 3));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
